alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single ALU instance between NREQ requesters, for example the execute stage and a branch/address helper unit.
- Each requester uses a valid/ready handshake. The arbiter grants round-robin and latches the winner's operands into registers that drive the ALU.
- It returns the ALU outputs, tagged with the requester id, through a valid/ready response port.
- One operation per cycle at full throughput. The ALU itself stays combinational and outside this block.

Parameters:
- NREQ, 2: number of requesters, 2..4.
- IDW, 2: width of the requester id; must satisfy 2**IDW >= NREQ.
- CNTW, 16: width of the accepted-operation counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit is high.
- req_x  input  32*NREQ  operand x, packed; requester i uses bits [32i+31:32i].
- req_y  input  32*NREQ  operand y, packed the same way.
- req_aluop  input  4*NREQ  ALU opcode, packed.
- req_shamt  input  5*NREQ  shift amount, packed.
- alu_x  output  32  registered operand to the ALU.
- alu_y  output  32  registered operand to the ALU.
- alu_op  output  4  registered opcode to the ALU.
- alu_shamt  output  5  registered shift amount to the ALU.
- alu_result  input  32  primary ALU result.
- alu_result2  input  32  secondary ALU result (high word / remainder).
- alu_equal  input  1  ALU x==y flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  32  equals alu_result.
- rsp_result2  output  32  equals alu_result2.
- rsp_equal  output  1  equals alu_equal.
- op_count  output  CNTW  number of accepted operations; wraps modulo 2**CNTW.

Interface rule: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_id=0, round-robin pointer=0, op_count=0.
  - alu_x/alu_y/alu_op/alu_shamt all 0.
  - req_ready=0 for every cycle in which rst is high.
- Slot state:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - The slot can take a new operation when `can_take = !rsp_valid || rsp_ready`.
- Grant (combinational):
  - Consider requesters with req_valid=1.
  - Pick the first one found scanning from pointer upward, wrapping at NREQ-1 back to 0.
  - req_ready[g]=1 only when can_take=1 and rst=0. All other bits are 0.
  - The grant has no dependence on any req_ready value, so no combinational loop.
- Accept: the cycle in which req_valid[g] && req_ready[g]. On the next edge:
  - Latch requester g's x, y, aluop and shamt into the alu_* registers.
  - rsp_id<=g, rsp_valid<=1.
  - pointer<=(g+1) mod NREQ.
  - op_count<=op_count+1.
- Latency: accept at edge n gives rsp_valid=1 after edge n. rsp_result, rsp_result2 and rsp_equal are combinational from the ALU, which is fed by the registered operands.
- Drain:
  - rsp_valid && rsp_ready with no new accept: rsp_valid<=0 at the next edge.
  - If a new accept happens in the same cycle, rsp_valid stays 1 and the new operands load. Back-to-back throughput is 1 operation per clock.
- Stall: while rsp_valid=1 and rsp_ready=0:
  - req_ready is all 0.
  - alu_* registers and rsp_id stay stable, so the response data is stable until consumed.
- Pointer: changes only on accept. With a single valid requester, that requester wins regardless of the pointer.
- Requester protocol:
  - A requester holds valid and its payload until it sees ready.
  - Payload is sampled only at the accept edge.
  - A requester that drops valid before ready is not granted; there is no grant lock.
- Reset mid-operation: any pending response is discarded, rsp_valid=0, pointer returns to 0. No response is produced for an accept that coincides with rst=1; req_ready is 0 in that cycle anyway.
- The block never modifies opcodes or operands. Opcode decode belongs to the ALU.

Decomposition:
- Shared package holds the ALU field widths: ALU_W=32, ALUOP_W=4, SHAMT_W=5.
- The round-robin picker is a natural sub-module, rr_pick.
  - Inputs: req[NREQ-1:0], ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational.
- The rest (operand registers, slot flag, counter) stays in the top module.

Test Plan:
- Bench setup: the real ALU is connected to the alu_* ports.
- Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0 throughout; rsp_valid=0, op_count=0 and alu_*=0 after the first edge.
- Single request: req 0 with x=32'h05010301, y=32'h52405760, aluop=4'h0, shamt=0, rsp_ready=1 -> req_ready[0]=1 in the same cycle. One cycle later rsp_valid=1, rsp_id=0, rsp_result equals the ALU model output for opcode 0, op_count=1.
- Fairness: both requesters valid continuously, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,0,1,0,1,0,1; op_count=8.
- Backpressure: a response is pending and rsp_ready=0 for 5 cycles while req 1 is valid -> req_ready=0 for those 5 cycles and rsp_result stays constant. When rsp_ready rises, req 1 is accepted in that same cycle and its response follows on the next cycle.
- Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 after the edge and the pointer returns to 0. With both requesters valid after reset, the first grant goes to 0.
- Counter wrap: preload traffic until op_count=16'hFFFF, then one more accept -> op_count=16'h0000.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared field widths and the operand bundle handed to the shared ALU.
package alu_share_arbiter_pkg;

  localparam int ALU_W   = 32;
  localparam int ALUOP_W = 4;
  localparam int SHAMT_W = 5;

  // One ALU operation as latched from the winning requester.
  typedef struct packed {
    logic [ALU_W-1:0]   x;
    logic [ALU_W-1:0]   y;
    logic [ALUOP_W-1:0] op;
    logic [SHAMT_W-1:0] shamt;
  } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, else the
// first one below it (wrap). Purely combinational.
module alu_share_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic           w_hi_any, w_lo_any;
  logic [IDW-1:0] w_hi_idx, w_lo_idx;

  // Scan high to low so the last hit in each half is its lowest index.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (IDW'(i) >= i_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = IDW'(i);
        end else begin
          w_lo_any = 1'b1;
          w_lo_idx = IDW'(i);
        end
      end
    end
  end

  assign o_any = w_hi_any | w_lo_any;
  assign o_idx = w_hi_any ? w_hi_idx : w_lo_idx;

  // One-hot form of the chosen index.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NREQ; i++)
      if (o_any && (o_idx == IDW'(i))) o_grant[i] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters. The winner's
// operands are registered into the ALU inputs; the ALU outputs come back
// through a one-deep valid/ready response slot tagged with the owner id.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [ALU_W*NREQ-1:0]   req_x,
  input  logic [ALU_W*NREQ-1:0]   req_y,
  input  logic [ALUOP_W*NREQ-1:0] req_aluop,
  input  logic [SHAMT_W*NREQ-1:0] req_shamt,
  output logic [ALU_W-1:0]        alu_x,
  output logic [ALU_W-1:0]        alu_y,
  output logic [ALUOP_W-1:0]      alu_op,
  output logic [SHAMT_W-1:0]      alu_shamt,
  input  logic [ALU_W-1:0]        alu_result,
  input  logic [ALU_W-1:0]        alu_result2,
  input  logic                    alu_equal,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [ALU_W-1:0]        rsp_result,
  output logic [ALU_W-1:0]        rsp_result2,
  output logic                    rsp_equal,
  output logic [CNTW-1:0]         op_count
);

  alu_req_t [NREQ-1:0] w_req;
  alu_req_t            w_sel;
  alu_req_t            r_alu;
  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_idx;
  logic                w_any;
  logic                w_take;
  logic                w_acc;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_rsp_id;
  logic                r_rsp_valid;
  logic [CNTW-1:0]     r_cnt;

  // Unpack the flat per-requester payload buses.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_req[i].x     = req_x[ALU_W*i +: ALU_W];
    assign w_req[i].y     = req_y[ALU_W*i +: ALU_W];
    assign w_req[i].op    = req_aluop[ALUOP_W*i +: ALUOP_W];
    assign w_req[i].shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
  end

  alu_share_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Slot accepts when empty or being drained this cycle; grant never
  // looks at req_ready, so there is no combinational loop.
  assign w_take    = !r_rsp_valid || rsp_ready;
  assign req_ready = (w_take && !rst) ? w_grant : '0;
  assign w_acc     = w_any && w_take && !rst;

  // One-hot AND-OR operand mux driven by the grant.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) w_sel = w_req[i];
  end

  // Operand registers, response slot, rr pointer and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu       <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else if (w_acc) begin
      r_alu       <= w_sel;
      r_rsp_id    <= w_idx;
      r_rsp_valid <= 1'b1;
      r_ptr       <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
      r_cnt       <= r_cnt + CNTW'(1);
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign alu_x       = r_alu.x;
  assign alu_y       = r_alu.y;
  assign alu_op      = r_alu.op;
  assign alu_shamt   = r_alu.shamt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = alu_result;
  assign rsp_result2 = alu_result2;
  assign rsp_equal   = alu_equal;
  assign op_count    = r_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the
// alu_* ports. Expected values are hand-computed constants.
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_x, req_y;
  logic [4*NREQ-1:0]    req_aluop;
  logic [5*NREQ-1:0]    req_shamt;
  logic [31:0]          alu_x, alu_y;
  logic [3:0]           alu_op;
  logic [4:0]           alu_shamt;
  logic [31:0]          alu_result, alu_result2;
  logic                 alu_equal;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_result, rsp_result2;
  logic                 rsp_equal;
  logic [CNTW-1:0]      op_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_aluop(req_aluop), .req_shamt(req_shamt),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_result2(alu_result2), .alu_equal(alu_equal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_result2(rsp_result2), .rsp_equal(rsp_equal),
    .op_count(op_count)
  );

  // Reference ALU: primary result by opcode, secondary is x^y.
  always_comb begin
    case (alu_op)
      4'h0:    alu_result = alu_x + alu_y;
      4'h1:    alu_result = alu_x - alu_y;
      4'h2:    alu_result = alu_x & alu_y;
      4'h3:    alu_result = alu_x | alu_y;
      4'h4:    alu_result = alu_x ^ alu_y;
      4'h5:    alu_result = alu_x << alu_shamt;
      default: alu_result = 32'h0;
    endcase
    alu_result2 = alu_x ^ alu_y;
    alu_equal   = (alu_x == alu_y);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] op, input logic [4:0] sh);
    req_x[32*i +: 32]   = x;
    req_y[32*i +: 32]   = y;
    req_aluop[4*i +: 4] = op;
    req_shamt[5*i +: 5] = sh;
  endtask

  initial begin
    int n;
    logic [1:0] exp_rdy;
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_x = '0; req_y = '0; req_aluop = '0; req_shamt = '0;
    set_req(0, 32'h1111_1111, 32'h2222_2222, 4'h0, 5'd0);
    set_req(1, 32'h3333_3333, 32'h4444_4444, 4'h0, 5'd0);

    // Reset held 3 cycles with every requester valid.
    #1 chk("rst_ready_c0", 32'(req_ready), 32'h0);
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    chk("rst_alu_x", alu_x, 32'h0);
    chk("rst_alu_y", alu_y, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_shamt", 32'(alu_shamt), 32'h0);
    chk("rst_ready_c1", 32'(req_ready), 32'h0);
    tick();
    chk("rst_ready_c2", 32'(req_ready), 32'h0);
    tick();

    // Single request from requester 0.
    rst = 1'b0;
    req_valid = 2'b01;
    set_req(0, 32'h0501_0301, 32'h5240_5760, 4'h0, 5'd0);
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h0);
    chk("single_result", rsp_result, 32'h5741_5A61);
    chk("single_result2", rsp_result2, 32'h5741_5461);
    chk("single_equal", 32'(rsp_equal), 32'h0);
    chk("single_op_count", 32'(op_count), 32'h1);

    // Requester 1 alone while pointer is 1; moves pointer back to 0.
    req_valid = 2'b10;
    set_req(1, 32'h0000_00F0, 32'h0000_0F0F, 4'h2, 5'd0);
    #1 chk("r1_ready", 32'(req_ready), 32'h2);
    tick();
    chk("r1_rsp_id", 32'(rsp_id), 32'h1);
    chk("r1_result", rsp_result, 32'h0000_0000);
    chk("r1_op_count", 32'(op_count), 32'h2);

    // Fairness: both valid for 8 cycles, ids alternate starting at 0.
    req_valid = 2'b11;
    set_req(0, 32'h0000_0001, 32'h0000_0002, 4'h0, 5'd0);
    set_req(1, 32'h0000_0010, 32'h0000_0010, 4'h1, 5'd0);
    for (int k = 0; k < 8; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("fair_ready", 32'(req_ready), 32'(exp_rdy));
      tick();
      chk("fair_rsp_id", 32'(rsp_id), 32'(k % 2));
      chk("fair_result", rsp_result, (k % 2 == 0) ? 32'h3 : 32'h0);
    end
    chk("fair_equal", 32'(rsp_equal), 32'h1);
    chk("fair_op_count", 32'(op_count), 32'd10);

    // Backpressure: pending id1 response, req 1 waits with new payload.
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    set_req(1, 32'hFFFF_0000, 32'h0000_FFFF, 4'h3, 5'd0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_result", rsp_result, 32'h0);
      chk("bp_rsp_id", 32'(rsp_id), 32'h1);
    end
    chk("bp_op_count", 32'(op_count), 32'd10);
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h2);
    tick();
    chk("bp_new_rsp_id", 32'(rsp_id), 32'h1);
    chk("bp_new_result", rsp_result, 32'hFFFF_FFFF);
    chk("bp_new_op_count", 32'(op_count), 32'd11);

    // Accept from req 0 so the pointer sits at 1 before reset.
    req_valid = 2'b01;
    set_req(0, 32'h0000_0007, 32'h0000_0003, 4'h1, 5'd0);
    tick();
    chk("pre_rst_result", rsp_result, 32'h4);

    // Reset while a response is stalled.
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    rst = 1'b1;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_alu_x", alu_x, 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("post_rst_op_count", 32'(op_count), 32'h1);

    // Counter wrap: run full throughput up to 16'hFFFF, then one more.
    n = 0;
    while (op_count !== 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    chk("wrap_reach_ffff", 32'(op_count), 32'h0000_FFFF);
    tick();
    chk("wrap_zero", 32'(op_count), 32'h0);

    // Drain: no requesters, consumer ready, slot empties.
    req_valid = 2'b00;
    #1 chk("drain_ready", 32'(req_ready), 32'h0);
    tick();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("drain_op_count", 32'(op_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
